timer_ctrl_master: RTL and testbench
====================================

# timer_ctrl_master

Hardware Avalon-MM initiator that owns the system interval timer's 16-bit register slave (six words, fixed read latency 1, no waitrequest) and runs it without CPU involvement. A local command port requests start, stop and snapshot; the block sequences the register writes and reads, services the timeout IRQ, counts timeouts and returns 32-bit snapshots. It sits beside the timer slave in the NiosII system, in place of software polling.

## Interface
- CNT_W, 16, width of timeout_count (wraps modulo 2^CNT_W)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_start  in  1  pulse: load cmd_period, start timer
- cmd_stop  in  1  pulse: stop timer
- cmd_snap  in  1  pulse: capture and read counter snapshot
- cmd_period  in  32  period value, sampled with cmd_start
- cmd_continuous  in  1  sampled with cmd_start; 1 = periodic, 0 = one-shot
- cmd_ready  out  1  commands accepted this cycle
- busy  out  1  timer started by this block and not yet stopped/expired
- tick  out  1  one-cycle pulse per serviced timeout
- timeout_count  out  CNT_W  serviced timeouts since reset
- snap_value  out  32  last snapshot {high, low}
- snap_valid  out  1  one-cycle pulse when snap_value updates
- err  out  1  one-cycle pulse: cmd_start with cmd_period == 0 (ignored, no bus traffic)
- tmr_address  out  3  slave word address
- tmr_chipselect  out  1  slave select
- tmr_write_n  out  1  0 = write, 1 = read
- tmr_writedata  out  16  write data
- tmr_readdata  in  16  slave read data, valid the cycle after the address cycle
- tmr_irq  in  1  timer interrupt (level)

## Operation
- Slave map: 0 status (any write clears timeout), 1 control {stop,start,cont,ito}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h (write either = take snapshot).
- Every bus access is exactly one cycle with chipselect=1; idle: chipselect=0, write_n=1, address=0, writedata=0.
- FSM states: IDLE, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT_IRQ, WR_STATUS, WR_STOP, SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP.
- cmd_ready = 1 only in IDLE and WAIT_IRQ; commands in other states are dropped.
- Start: WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> SETTLE (no access; absorbs slave force_reload) -> WR_CTRL (addr 1, data 0x4 | cont<<1 | 1) -> WAIT_IRQ, busy=1.
- WAIT_IRQ priority, highest first: tmr_irq, cmd_stop, cmd_snap, cmd_start (restart with new period).
- tmr_irq: WR_STATUS (addr 0, data 0), tick=1 and timeout_count+1 in that cycle; then WAIT_IRQ if continuous, else IDLE with busy=0.
- cmd_stop: WR_STOP (addr 1, data 0x8 | cont<<1 | 1) -> IDLE, busy=0. In IDLE cmd_stop is ignored.
- cmd_snap (IDLE or WAIT_IRQ): SNAP_WR (write addr 4, data 0) -> SNAP_RD_L (read addr 4) -> SNAP_RD_H (read addr 5; capture readdata as low) -> SNAP_CAP (capture readdata as high; snap_valid=1) -> return to originating state.
- Timeout arriving during a snapshot or stop sequence is serviced on return to WAIT_IRQ (irq is level); after WR_STOP irq is ignored in IDLE.
- Priority in IDLE: cmd_snap over cmd_start.

## Timing
- Reset: all outputs 0 except tmr_write_n=1; state IDLE; cmd_ready=1 on first cycle after reset release.
- Start latency: cmd_start at cycle 0 -> accesses at cycles 1, 2, 4; busy=1 from cycle 5.
- IRQ service: tmr_irq sampled high in WAIT_IRQ at cycle n -> status write and tick at n+1; irq low at n+2, no double count.
- Snapshot: cmd_snap at cycle 0 -> snap_valid and snap_value at cycle 4 (registered output, visible cycle 5).
- timeout_count wraps from 2^CNT_W-1 to 0 without flag.
- Reset mid-sequence: immediate return to IDLE, bus idle; timer slave state not assumed.

## Test plan
- Reset -> all outputs 0, tmr_write_n=1, cmd_ready=1, bus idle.
- cmd_start, period 0x0001_0005, continuous=1, slave model -> writes (2,0x0005),(3,0x0001),(1,0x0007) at cycles 1,2,4; three irqs -> 3 ticks, timeout_count=3, busy stays 1.
- One-shot period 10 -> one status write, tick once, busy falls, later irq ignored in IDLE.
- cmd_snap while running with slave counter 0x0001_2345 at snapshot -> write addr 4, reads 4 then 5, snap_value=0x00012345, snap_valid at cycle 4.
- irq and cmd_stop same cycle in WAIT_IRQ -> status write first, then stop serviced only if reissued; cmd_start period 0 -> err pulse, no bus access.
- CNT_W=2, five timeouts -> timeout_count 1,2,3,0,1.

Source files
------------

// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator that drives the interval timer register slave on behalf of
// a local start/stop/snapshot command port, servicing and counting timeouts.
module timer_ctrl_master #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_snap,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_continuous,
  output logic             cmd_ready,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] timeout_count,
  output logic [31:0]      snap_value,
  output logic             snap_valid,
  output logic             err,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq
);

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    SETTLE,
    WR_CTRL,
    WAIT_IRQ,
    WR_STATUS,
    WR_STOP,
    SNAP_WR,
    SNAP_RD_L,
    SNAP_RD_H,
    SNAP_CAP
  } state_t;

  state_t      state;
  state_t      next_state;
  state_t      ret_state;
  logic [31:0] period;
  logic        cont;
  logic [15:0] snap_low;
  logic        accept_start;
  logic        zero_start;

  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_snap) begin
          next_state = SNAP_WR;
        end else if (cmd_start) begin
          if (cmd_period != 32'd0) begin
            next_state   = WR_PL;
            accept_start = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      WR_PL:   next_state = WR_PH;
      WR_PH:   next_state = SETTLE;
      SETTLE:  next_state = WR_CTRL;
      WR_CTRL: next_state = WAIT_IRQ;
      // The irq is a level, so anything deferred here is picked up on return.
      WAIT_IRQ: begin
        if (tmr_irq) begin
          next_state = WR_STATUS;
        end else if (cmd_stop) begin
          next_state = WR_STOP;
        end else if (cmd_snap) begin
          next_state = SNAP_WR;
        end else if (cmd_start) begin
          if (cmd_period != 32'd0) begin
            next_state   = WR_PL;
            accept_start = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      WR_STATUS: next_state = cont ? WAIT_IRQ : IDLE;
      WR_STOP:   next_state = IDLE;
      SNAP_WR:   next_state = SNAP_RD_L;
      SNAP_RD_L: next_state = SNAP_RD_H;
      SNAP_RD_H: next_state = SNAP_CAP;
      SNAP_CAP:  next_state = ret_state;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'd0;
    case (state)
      WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd2;
        tmr_writedata  = period[15:0];
      end
      WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd3;
        tmr_writedata  = period[31:16];
      end
      WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = {13'd0, 1'b1, cont, 1'b1};
      end
      WR_STATUS: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
      end
      WR_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = {12'd0, 1'b1, 1'b0, cont, 1'b1};
      end
      SNAP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd4;
      end
      SNAP_RD_L: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 3'd4;
      end
      SNAP_RD_H: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 3'd5;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE) || (state == WAIT_IRQ);
  assign tick      = (state == WR_STATUS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ret_state     <= IDLE;
      period        <= 32'd0;
      cont          <= 1'b0;
      snap_low      <= 16'd0;
      snap_value    <= 32'd0;
      snap_valid    <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      timeout_count <= '0;
    end else begin
      state      <= next_state;
      snap_valid <= 1'b0;
      err        <= zero_start;
      if (accept_start) begin
        period <= cmd_period;
        cont   <= cmd_continuous;
      end
      if (((state == IDLE) || (state == WAIT_IRQ)) && (next_state == SNAP_WR)) begin
        ret_state <= state;
      end
      // Read data lags the address cycle by one, hence the offset capture states.
      if (state == SNAP_RD_H) begin
        snap_low <= tmr_readdata;
      end
      if (state == SNAP_CAP) begin
        snap_value <= {tmr_readdata, snap_low};
        snap_valid <= 1'b1;
      end
      if (state == WR_CTRL) begin
        busy <= 1'b1;
      end else if ((state == WR_STOP) || ((state == WR_STATUS) && !cont)) begin
        busy <= 1'b0;
      end
      if (state == WR_STATUS) begin
        timeout_count <= timeout_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master: directed commands push expected bus
// accesses and events; a negedge monitor pops and compares them as they appear.
module tb_timer_ctrl_master;

  localparam int K_ACC  = 0;
  localparam int K_TICK = 1;
  localparam int K_SNAP = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic        wn;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start, cmd_stop, cmd_snap, cmd_continuous;
  logic [31:0] cmd_period;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  logic        cmd_ready, busy, tick, snap_valid, err;
  logic [15:0] timeout_count;
  logic [31:0] snap_value;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;

  logic        d2_cmd_ready, d2_busy, d2_tick, d2_snap_valid, d2_err;
  logic [1:0]  d2_timeout_count;
  logic [31:0] d2_snap_value;
  logic [2:0]  d2_tmr_address;
  logic        d2_tmr_chipselect, d2_tmr_write_n;
  logic [15:0] d2_tmr_writedata;

  logic [31:0] slave_counter;
  logic [31:0] snap_reg;
  int          cyc = 0;
  int          base;
  int          exp_count;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_ctrl_master #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_ready(cmd_ready), .busy(busy), .tick(tick), .timeout_count(timeout_count),
    .snap_value(snap_value), .snap_valid(snap_valid), .err(err),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  // Narrow-counter copy on the same stimulus, used to observe wraparound.
  timer_ctrl_master #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_ready(d2_cmd_ready), .busy(d2_busy), .tick(d2_tick), .timeout_count(d2_timeout_count),
    .snap_value(d2_snap_value), .snap_valid(d2_snap_valid), .err(d2_err),
    .tmr_address(d2_tmr_address), .tmr_chipselect(d2_tmr_chipselect),
    .tmr_write_n(d2_tmr_write_n), .tmr_writedata(d2_tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  // Timer slave snapshot path: a write to word 4/5 latches the counter, reads return it one cycle later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_reg     <= 32'd0;
      tmr_readdata <= 16'd0;
    end else begin
      if (tmr_chipselect && !tmr_write_n && ((tmr_address == 3'd4) || (tmr_address == 3'd5)))
        snap_reg <= slave_counter;
      if (tmr_chipselect && tmr_write_n) begin
        case (tmr_address)
          3'd4:    tmr_readdata <= snap_reg[15:0];
          3'd5:    tmr_readdata <= snap_reg[31:16];
          default: tmr_readdata <= 16'd0;
        endcase
      end else begin
        tmr_readdata <= 16'd0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic popCheck(input int kind, input logic [31:0] a, input logic [31:0] b, input logic wn);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_event: kind %0d at cycle %0d, none required", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (kind == e.kind) begin
        case (kind)
          K_ACC: begin
            checkOutput("acc_address", a, e.a);
            checkOutput("acc_write_n", {31'd0, wn}, {31'd0, e.wn});
            if (!e.wn) checkOutput("acc_writedata", b, e.b);
          end
          K_TICK: begin
            checkOutput("tick_count", a, e.a);
            checkOutput("tick_count_w2", b, e.b);
          end
          K_SNAP:  checkOutput("snap_value", a, e.a);
          default: ;
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (tmr_chipselect)
        popCheck(K_ACC, {29'd0, tmr_address}, {16'd0, tmr_writedata}, tmr_write_n);
      else
        checkOutput("bus_idle", {12'd0, tmr_address, tmr_write_n, tmr_writedata}, 32'h0001_0000);
      if (tick) popCheck(K_TICK, {16'd0, timeout_count}, {30'd0, d2_timeout_count}, 1'b0);
      if (snap_valid) popCheck(K_SNAP, snap_value, 32'd0, 1'b0);
      if (err) popCheck(K_ERR, 32'd0, 32'd0, 1'b0);
    end
  end

  function automatic void pushExp(input int kind, input int c, input logic [31:0] a,
                                  input logic [31:0] b, input logic wn);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.b    = b;
    e.wn   = wn;
    exp_q.push_back(e);
  endfunction

  function automatic void expAcc(input int c, input logic [2:0] addr, input logic wn, input logic [15:0] d);
    pushExp(K_ACC, c, {29'd0, addr}, {16'd0, d}, wn);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic snap,
                               input logic [31:0] per, input logic cont);
    cmd_start      = start;
    cmd_stop       = stop;
    cmd_snap       = snap;
    cmd_period     = per;
    cmd_continuous = cont;
    waitCycles(1);
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_snap  = 1'b0;
  endtask

  // The slave drops irq after the status write, i.e. two cycles after it was raised.
  task automatic raiseIrq(input logic with_stop);
    int n;
    n = cyc;
    tmr_irq  = 1'b1;
    cmd_stop = with_stop;
    expAcc(n + 1, 3'd0, 1'b0, 16'h0000);
    pushExp(K_TICK, n + 1, exp_count, exp_count % 4, 1'b0);
    exp_count++;
    waitCycles(1);
    cmd_stop = 1'b0;
    waitCycles(1);
    tmr_irq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    cmd_start      = 1'b0;
    cmd_stop       = 1'b0;
    cmd_snap       = 1'b0;
    cmd_period     = 32'd0;
    cmd_continuous = 1'b0;
    tmr_irq        = 1'b0;
    slave_counter  = 32'd0;
    exp_count      = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_tick", {31'd0, tick}, 32'd0);
    checkOutput("rst_count", {16'd0, timeout_count}, 32'd0);
    checkOutput("rst_snap_value", snap_value, 32'd0);
    checkOutput("rst_flags", {30'd0, snap_valid, err}, 32'd0);
    checkOutput("rst_bus", {11'd0, tmr_chipselect, tmr_address, tmr_write_n, tmr_writedata}, 32'h0001_0000);
    @(posedge clk);
    #1;

    $display("[TB] continuous start, period 0x00010005");
    base = cyc;
    expAcc(base + 1, 3'd2, 1'b0, 16'h0005);
    expAcc(base + 2, 3'd3, 1'b0, 16'h0001);
    expAcc(base + 4, 3'd1, 1'b0, 16'h0007);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0001_0005, 1'b1);
    waitCycles(3);
    checkOutput("busy_before_ctrl_done", {31'd0, busy}, 32'd0);
    waitCycles(1);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (3) begin
      raiseIrq(1'b0);
      waitCycles(2);
    end
    checkOutput("count_after_3", {16'd0, timeout_count}, 32'd3);
    checkOutput("busy_continuous", {31'd0, busy}, 32'd1);

    $display("[TB] stop");
    base = cyc;
    expAcc(base + 1, 3'd1, 1'b0, 16'h000B);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    waitCycles(1);
    checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);

    $display("[TB] one-shot start, period 10");
    base = cyc;
    expAcc(base + 1, 3'd2, 1'b0, 16'h000A);
    expAcc(base + 2, 3'd3, 1'b0, 16'h0000);
    expAcc(base + 4, 3'd1, 1'b0, 16'h0005);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd10, 1'b0);
    waitCycles(4);
    raiseIrq(1'b0);
    checkOutput("busy_oneshot_expired", {31'd0, busy}, 32'd0);
    tmr_irq = 1'b1;
    waitCycles(4);
    tmr_irq = 1'b0;
    waitCycles(1);
    checkOutput("count_irq_in_idle", {16'd0, timeout_count}, 32'd4);

    $display("[TB] snapshot while running");
    slave_counter = 32'h0001_2345;
    base = cyc;
    expAcc(base + 1, 3'd2, 1'b0, 16'h0100);
    expAcc(base + 2, 3'd3, 1'b0, 16'h0000);
    expAcc(base + 4, 3'd1, 1'b0, 16'h0007);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1);
    waitCycles(4);
    base = cyc;
    expAcc(base + 1, 3'd4, 1'b0, 16'h0000);
    expAcc(base + 2, 3'd4, 1'b1, 16'h0000);
    expAcc(base + 3, 3'd5, 1'b1, 16'h0000);
    pushExp(K_SNAP, base + 5, 32'h0001_2345, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    waitCycles(4);
    checkOutput("busy_after_snap", {31'd0, busy}, 32'd1);
    checkOutput("ready_after_snap", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] irq and stop in the same cycle");
    raiseIrq(1'b1);
    waitCycles(2);
    checkOutput("busy_stop_dropped", {31'd0, busy}, 32'd1);
    checkOutput("count_after_5", {16'd0, timeout_count}, 32'd5);
    checkOutput("count_w2_wrapped", {30'd0, d2_timeout_count}, 32'd1);
    base = cyc;
    expAcc(base + 1, 3'd1, 1'b0, 16'h000B);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    waitCycles(1);
    checkOutput("busy_after_reissued_stop", {31'd0, busy}, 32'd0);

    $display("[TB] zero-period start");
    base = cyc;
    pushExp(K_ERR, base + 1, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    waitCycles(3);
    checkOutput("busy_zero_period", {31'd0, busy}, 32'd0);

    $display("[TB] snapshot from idle");
    slave_counter = 32'hABCD_0001;
    base = cyc;
    expAcc(base + 1, 3'd4, 1'b0, 16'h0000);
    expAcc(base + 2, 3'd4, 1'b1, 16'h0000);
    expAcc(base + 3, 3'd5, 1'b1, 16'h0000);
    pushExp(K_SNAP, base + 5, 32'hABCD_0001, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    waitCycles(6);
    checkOutput("snap_hold", snap_value, 32'hABCD_0001);
    checkOutput("busy_idle_snap", {31'd0, busy}, 32'd0);
    checkOutput("ready_idle_snap", {31'd0, cmd_ready}, 32'd1);

    checkOutput("pending_events", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
